keypad_scan: RTL

KEYPAD_SCAN -- requirements
Module: keypad_scan

---
 rtl/keypad_scan.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/keypad_scan.sv
// 4x4 matrix keypad scanner: one-cold row drive, synchronised columns, tick-based debounce.
// Optional auto-repeat while held is enabled by defining KEYPAD_REPEAT_EN.
module keypad_scan #(
  parameter int SCAN_DIV   = 6250,
  parameter int DEB_TICKS  = 4,
  parameter int REPEAT_DLY = 200,
  parameter int REPEAT_PER = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] col,
  output logic [3:0] row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_down
);

  localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DEB_W = $clog2(DEB_TICKS + 1);
`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int REP_W   = $clog2(REP_MAX + 1);
`endif

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} state_t;

  logic [3:0]       col_meta_reg;
  logic [3:0]       col_sync_reg;
  logic [DIV_W-1:0] div_cnt_reg;
  logic             tick;
  state_t           state_reg;
  logic [3:0]       row_reg;
  logic [1:0]       row_idx_reg;
  logic [1:0]       col_idx_reg;
  logic [3:0]       pat_reg;
  logic [DEB_W-1:0] deb_cnt_reg;
  logic [3:0]       key_code_reg;
  logic             key_valid_reg;
  logic             key_down_reg;
  logic             single_low;
  logic [1:0]       low_idx;
`ifdef KEYPAD_REPEAT_EN
  logic [REP_W-1:0] rep_cnt_reg;
  logic             rep_first_reg;
`endif

  // Two-flop synchroniser per column; idle level is high (pull-ups).
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          col_meta_reg[gi] <= 1'b1;
          col_sync_reg[gi] <= 1'b1;
        end else begin
          col_meta_reg[gi] <= col[gi];
          col_sync_reg[gi] <= col_meta_reg[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      div_cnt_reg <= '0;
    else if (div_cnt_reg == DIV_W'(SCAN_DIV - 1))
      div_cnt_reg <= '0;
    else
      div_cnt_reg <= div_cnt_reg + DIV_W'(1);
  end

  assign tick = (div_cnt_reg == DIV_W'(SCAN_DIV - 1));

  always_comb begin
    single_low = 1'b0;
    low_idx    = 2'd0;
    case (col_sync_reg)
      4'b1110: begin single_low = 1'b1; low_idx = 2'd0; end
      4'b1101: begin single_low = 1'b1; low_idx = 2'd1; end
      4'b1011: begin single_low = 1'b1; low_idx = 2'd2; end
      4'b0111: begin single_low = 1'b1; low_idx = 2'd3; end
      default: begin single_low = 1'b0; low_idx = 2'd0; end
    endcase
  end

  // Row stays frozen outside SCAN, so row_idx_reg doubles as the captured row.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= SCAN;
      row_reg       <= 4'b1110;
      row_idx_reg   <= 2'd0;
      col_idx_reg   <= 2'd0;
      pat_reg       <= 4'hF;
      deb_cnt_reg   <= '0;
      key_code_reg  <= 4'd0;
      key_valid_reg <= 1'b0;
      key_down_reg  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_cnt_reg   <= '0;
      rep_first_reg <= 1'b0;
`endif
    end else begin
      key_valid_reg <= 1'b0;
      if (tick) begin
        case (state_reg)
          SCAN: begin
            if (single_low) begin
              pat_reg     <= col_sync_reg;
              col_idx_reg <= low_idx;
              deb_cnt_reg <= DEB_W'(1);
              state_reg   <= DEBOUNCE;
            end else begin
              row_reg     <= {row_reg[2:0], row_reg[3]};
              row_idx_reg <= row_idx_reg + 2'd1;
            end
          end
          DEBOUNCE: begin
            if (col_sync_reg == pat_reg) begin
              if (deb_cnt_reg == DEB_W'(DEB_TICKS - 1)) begin
                state_reg     <= HELD;
                key_valid_reg <= 1'b1;
                key_code_reg  <= {row_idx_reg, col_idx_reg};
                key_down_reg  <= 1'b1;
`ifdef KEYPAD_REPEAT_EN
                rep_cnt_reg   <= '0;
                rep_first_reg <= 1'b1;
`endif
              end else begin
                deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
              end
            end else begin
              state_reg   <= SCAN;
              row_reg     <= {row_reg[2:0], row_reg[3]};
              row_idx_reg <= row_idx_reg + 2'd1;
            end
          end
          HELD: begin
            if (col_sync_reg == 4'hF) begin
              state_reg   <= RELEASE;
              deb_cnt_reg <= DEB_W'(1);
            end else begin
`ifdef KEYPAD_REPEAT_EN
              // Repeat count only advances on held ticks and survives release glitches.
              if (rep_cnt_reg == (rep_first_reg ? REP_W'(REPEAT_DLY - 1) : REP_W'(REPEAT_PER - 1))) begin
                key_valid_reg <= 1'b1;
                rep_cnt_reg   <= '0;
                rep_first_reg <= 1'b0;
              end else begin
                rep_cnt_reg <= rep_cnt_reg + REP_W'(1);
              end
`endif
            end
          end
          RELEASE: begin
            if (col_sync_reg == 4'hF) begin
              if (deb_cnt_reg == DEB_W'(DEB_TICKS - 1)) begin
                key_down_reg <= 1'b0;
                state_reg    <= SCAN;
                row_reg      <= {row_reg[2:0], row_reg[3]};
                row_idx_reg  <= row_idx_reg + 2'd1;
              end else begin
                deb_cnt_reg <= deb_cnt_reg + DEB_W'(1);
              end
            end else begin
              state_reg <= HELD;
            end
          end
          default: state_reg <= SCAN;
        endcase
      end
    end
  end

  assign row       = row_reg;
  assign key_code  = key_code_reg;
  assign key_valid = key_valid_reg;
  assign key_down  = key_down_reg;

endmodule
